// File: rtl/prog_loader.sv
// Host-side program loader and run sequencer for the 9-bit CPU: streams words into
// instruction memory from address 0, pulses start, then times the run until done.
module prog_loader #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int START_CYC = 2,
  parameter int CNT_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_data,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              run_done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int SC_W = $clog2(START_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [SC_W-1:0]   SC_LOAD   = SC_W'(START_CYC - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_FINISH,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [SC_W-1:0]    start_cnt_q, start_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [8:0]         wr_data_q, wr_data_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               run_done_q, run_done_d;
  logic               error_q, error_d;
  logic [ADDR_W:0]    loaded_count_q, loaded_count_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready = (state_q == S_LOAD) || (state_q == S_FINISH);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    start_cnt_d    = start_cnt_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    start_d        = start_q;
    busy_d         = busy_q;
    run_done_d     = run_done_q;
    error_d        = error_q;
    loaded_count_d = loaded_count_q;
    cycle_count_d  = cycle_count_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          wr_en_d        = 1'b1;
          wr_addr_d      = ptr_q;
          wr_data_d      = in_data;
          ptr_d          = ptr_q + 1'b1;
          loaded_count_d = loaded_count_q + 1'b1;
          if (in_last) begin
            state_d     = S_START;
            start_d     = 1'b1;
            busy_d      = 1'b1;
            start_cnt_d = SC_LOAD;
          end else if (ptr_q == LAST_ADDR) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      S_START: begin
        if (start_cnt_q == '0) begin
          state_d = S_RUN;
          start_d = 1'b0;
        end else begin
          start_cnt_d = start_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (done) begin
          state_d    = S_FINISH;
          run_done_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cycle_count_d = sat_inc(cycle_count_q);
        end
      end
      S_FINISH: begin
        // A new word here restarts the load at address 0 and discards the old run result.
        if (accept) begin
          wr_en_d        = 1'b1;
          wr_addr_d      = '0;
          wr_data_d      = in_data;
          ptr_d          = ADDR_W'(1);
          loaded_count_d = (ADDR_W + 1)'(1);
          run_done_d     = 1'b0;
          cycle_count_d  = '0;
          state_d        = S_LOAD;
          if (in_last) begin
            state_d     = S_START;
            start_d     = 1'b1;
            busy_d      = 1'b1;
            start_cnt_d = SC_LOAD;
          end
        end
      end
      S_ERR: begin
        error_d = 1'b1;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_LOAD;
      ptr_q          <= '0;
      start_cnt_q    <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      run_done_q     <= 1'b0;
      error_q        <= 1'b0;
      loaded_count_q <= '0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      start_cnt_q    <= start_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      run_done_q     <= run_done_d;
      error_q        <= error_d;
      loaded_count_q <= loaded_count_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign run_done     = run_done_q;
  assign error        = error_q;
  assign loaded_count = loaded_count_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load, start pulse, run timing, overflow, reset and reload.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic        in_last;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [8:0]  wr_data;
  logic        start;
  logic        done;
  logic        busy;
  logic        run_done;
  logic        error;
  logic [10:0] loaded_count;
  logic [23:0] cycle_count;

  int n_vec;
  int n_err;

  prog_loader #(
    .DEPTH(1024), .ADDR_W(10), .START_CYC(2), .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .done(done), .busy(busy),
    .run_done(run_done), .error(error), .loaded_count(loaded_count),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are read 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    chk({tag, ".wr_en"}, 32'(wr_en), 0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
    chk({tag, ".wr_data"}, 32'(wr_data), 0);
    chk({tag, ".start"}, 32'(start), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".run_done"}, 32'(run_done), 0);
    chk({tag, ".error"}, 32'(error), 0);
    chk({tag, ".loaded_count"}, 32'(loaded_count), 0);
    chk({tag, ".cycle_count"}, 32'(cycle_count), 0);
  endtask

  initial begin
    logic [8:0] words [3];
    logic       gap_v [6];
    logic [8:0] gap_d [6];
    int         exp_addr;

    n_vec = 0; n_err = 0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; done = 1'b0;
    #2;
    do_reset();
    chk_reset_state("rst");

    // Short program, with done held high through START.
    words[0] = 9'h1A3; words[1] = 9'h0FF; words[2] = 9'h100;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i]; in_last = (i == 2);
      if (i == 2) done = 1'b1;
      tick();
      chk("short.wr_en", 32'(wr_en), 1);
      chk("short.wr_addr", 32'(wr_addr), 32'(i));
      chk("short.wr_data", 32'(wr_data), 32'(words[i]));
      chk("short.loaded", 32'(loaded_count), 32'(i + 1));
      chk("short.start", 32'(start), (i == 2) ? 1 : 0);
      chk("short.in_ready", 32'(in_ready), (i == 2) ? 0 : 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("short.busy", 32'(busy), 1);
    tick();
    chk("start2.start", 32'(start), 1);
    chk("start2.wr_en", 32'(wr_en), 0);
    tick();
    chk("run1.start", 32'(start), 0);
    chk("run1.busy", 32'(busy), 1);
    chk("run1.run_done", 32'(run_done), 0);
    chk("run1.cycle_count", 32'(cycle_count), 0);
    done = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    chk("run8.cycle_count", 32'(cycle_count), 7);
    chk("run8.run_done", 32'(run_done), 0);
    done = 1'b1;
    tick();
    chk("fin.cycle_count", 32'(cycle_count), 7);
    chk("fin.run_done", 32'(run_done), 1);
    chk("fin.busy", 32'(busy), 0);
    chk("fin.in_ready", 32'(in_ready), 1);
    tick();
    tick();
    chk("fin_hold.cycle_count", 32'(cycle_count), 7);
    chk("fin_hold.run_done", 32'(run_done), 1);
    chk("fin_hold.start", 32'(start), 0);
    done = 1'b0;

    // Reload from FINISH.
    in_valid = 1'b1; in_data = 9'h055; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("reload.wr_en", 32'(wr_en), 1);
    chk("reload.wr_addr", 32'(wr_addr), 0);
    chk("reload.wr_data", 32'(wr_data), 32'h055);
    chk("reload.loaded", 32'(loaded_count), 1);
    chk("reload.run_done", 32'(run_done), 0);
    chk("reload.cycle_count", 32'(cycle_count), 0);
    chk("reload.start", 32'(start), 1);
    tick();
    chk("reload.start2", 32'(start), 1);
    tick();
    chk("reload.run.start", 32'(start), 0);

    // Reset mid-run at cycle_count 5.
    for (int k = 0; k < 5; k++) tick();
    chk("midrun.cycle_count", 32'(cycle_count), 5);
    chk("midrun.busy", 32'(busy), 1);
    do_reset();
    chk_reset_state("midrst");
    in_valid = 1'b1; in_data = 9'h0AA; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("postrst.wr_en", 32'(wr_en), 1);
    chk("postrst.wr_addr", 32'(wr_addr), 0);
    chk("postrst.wr_data", 32'(wr_data), 32'h0AA);
    chk("postrst.loaded", 32'(loaded_count), 1);

    // Gapped input.
    do_reset();
    gap_v[0] = 1; gap_v[1] = 0; gap_v[2] = 0; gap_v[3] = 1; gap_v[4] = 0; gap_v[5] = 1;
    gap_d[0] = 9'h011; gap_d[1] = 9'h1FF; gap_d[2] = 9'h1EE;
    gap_d[3] = 9'h022; gap_d[4] = 9'h1DD; gap_d[5] = 9'h033;
    exp_addr = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = gap_v[i]; in_data = gap_d[i]; in_last = (i == 5);
      tick();
      chk("gap.wr_en", 32'(wr_en), 32'(gap_v[i]));
      if (gap_v[i]) begin
        chk("gap.wr_addr", 32'(wr_addr), 32'(exp_addr));
        chk("gap.wr_data", 32'(wr_data), 32'(gap_d[i]));
        exp_addr++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("gap.loaded", 32'(loaded_count), 3);
    chk("gap.start", 32'(start), 1);

    // Overflow: 1024 words, no last.
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_data = 9'(i) ^ 9'h155; in_last = 1'b0;
      tick();
      chk("ovf.wr_addr", 32'(wr_addr), 32'(i));
      chk("ovf.wr_data", 32'(wr_data), 32'(9'(i) ^ 9'h155));
      chk("ovf.start", 32'(start), 0);
    end
    chk("ovf.wr_en", 32'(wr_en), 1);
    chk("ovf.loaded", 32'(loaded_count), 1024);
    chk("ovf.error", 32'(error), 1);
    chk("ovf.in_ready", 32'(in_ready), 0);
    done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("err.wr_en", 32'(wr_en), 0);
      chk("err.start", 32'(start), 0);
      chk("err.error", 32'(error), 1);
      chk("err.in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0; done = 1'b0;

    // 1024 words with last on the final one.
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_data = 9'(i); in_last = (i == 1023);
      tick();
      chk("full.wr_addr", 32'(wr_addr), 32'(i));
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("full.loaded", 32'(loaded_count), 1024);
    chk("full.error", 32'(error), 0);
    chk("full.start", 32'(start), 1);
    chk("full.in_ready", 32'(in_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
